user_au_i2s_tx: RTL and testbench



---
 rtl/user_au_pkg.sv | 39 +++
 rtl/user_au_i2s_tx_if.sv | 19 +
 rtl/user_au_i2s_serializer.sv | 123 ++++++++++++
 rtl/user_au_i2s_tx.sv | 117 +++++++++++
 tb/tb_user_au_i2s_tx.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/user_au_pkg.sv
`default_nettype none
// ============================================================================
// Module : user_au_pkg
// Desc   : Register map, frame geometry and OBI types for the I2S audio output.
// Rev    : 1.0 - initial release
// ============================================================================
package user_au_pkg;

   localparam logic [3:0]  c_reg_ctrl   = 4'h0;
   localparam logic [3:0]  c_reg_clkdiv = 4'h4;
   localparam logic [3:0]  c_reg_status = 4'h8;
   localparam int unsigned c_ctrl_en    = 0;

   localparam int unsigned c_frame_len  = 64;
   localparam int unsigned c_slot_width = 32;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  aid;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic [3:0]  rid;
      logic        err;
   } obi_rsp_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } i2s_state_e;

endpackage
`default_nettype wire

// File: rtl/user_au_i2s_tx_if.sv
`default_nettype none
// ============================================================================
// Module : user_au_i2s_tx_if
// Desc   : OBI register port plus valid/ready sample stream of the I2S output.
// Rev    : 1.0 - initial release
// ============================================================================
interface user_au_i2s_tx_if;
   import user_au_pkg::*;

   obi_req_t    obi_req_i;
   obi_rsp_t    obi_rsp_o;
   logic [31:0] data_i;
   logic        valid_i;
   logic        ready_o;

   modport master (output obi_req_i, data_i, valid_i, input obi_rsp_o, ready_o);
   modport slave  (input obi_req_i, data_i, valid_i, output obi_rsp_o, ready_o);
endinterface
`default_nettype wire

// File: rtl/user_au_i2s_serializer.sv
`default_nettype none
// ============================================================================
// Module : user_au_i2s_serializer
// Desc   : SCK divider, bit counter and WS/SD generation; USER_AU_I2S_DELAY_EN
//          selects Philips I2S (one SCK delay) instead of left-justified.
// Rev    : 1.0 - initial release
// ============================================================================
module user_au_i2s_serializer
   import user_au_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_en,
   input  logic [15:0] i_div,
   input  logic [31:0] i_word,
   output logic        o_pop,
   output logic        o_sck,
   output logic        o_ws,
   output logic        o_sd
);
   localparam logic [5:0] c_last_bit = 6'(c_frame_len - 1);
   localparam logic [4:0] c_slot_msb = 5'(c_slot_width - 1);

   i2s_state_e  r_state, w_state_next;
   logic [15:0] r_cnt, w_cnt_next;
   logic [15:0] r_div, w_div_next;
   logic [5:0]  r_bit, w_bit_next;
   logic [31:0] r_word, w_word_next;
   logic        r_sck, w_sck_next;
   logic        r_ws, w_ws_next;
   logic        r_sd, w_sd_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_div   <= '0;
         r_bit   <= '0;
         r_word  <= '0;
         r_sck   <= 1'b0;
         r_ws    <= 1'b0;
         r_sd    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_div   <= w_div_next;
         r_bit   <= w_bit_next;
         r_word  <= w_word_next;
         r_sck   <= w_sck_next;
         r_ws    <= w_ws_next;
         r_sd    <= w_sd_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_div_next   = r_div;
      w_bit_next   = r_bit;
      w_word_next  = r_word;
      w_sck_next   = r_sck;
      w_ws_next    = r_ws;
      w_sd_next    = r_sd;
      o_pop        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_en) begin
               w_state_next = ST_RUN;
               w_cnt_next   = '0;
               w_div_next   = i_div;
               w_sck_next   = 1'b0;
               w_bit_next   = '0;
               o_pop        = 1'b1;
               w_word_next  = i_word;
               w_ws_next    = 1'b0;
`ifdef USER_AU_I2S_DELAY_EN
               w_sd_next    = 1'b0;
`else
               w_sd_next    = i_word[c_slot_msb];
`endif
            end
         end
         ST_RUN: begin
            if (!i_en) begin
               w_state_next = ST_IDLE;
               w_cnt_next   = '0;
               w_bit_next   = '0;
               w_sck_next   = 1'b0;
               w_ws_next    = 1'b0;
               w_sd_next    = 1'b0;
            end else if (r_cnt == r_div) begin
               // The divider value is resampled only here so a DIV write lands on a reload.
               w_cnt_next = '0;
               w_div_next = i_div;
               w_sck_next = ~r_sck;
               if (r_sck) begin
                  w_bit_next = r_bit + 6'd1;
                  if (r_bit == c_last_bit) begin
                     o_pop       = 1'b1;
                     w_word_next = i_word;
                  end
`ifdef USER_AU_I2S_DELAY_EN
                  w_ws_next = r_bit[5];
                  w_sd_next = r_word[c_slot_msb - r_bit[4:0]];
`else
                  w_ws_next = w_bit_next[5];
                  w_sd_next = w_word_next[c_slot_msb - w_bit_next[4:0]];
`endif
               end
            end else begin
               w_cnt_next = r_cnt + 16'd1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign o_sck = r_sck;
   assign o_ws  = r_ws;
   assign o_sd  = r_sd;

endmodule
`default_nettype wire

// File: rtl/user_au_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module : user_au_i2s_tx
// Desc   : Sample FIFO, OBI control/status registers and I2S serializer.
//          Output format selected by USER_AU_I2S_DELAY_EN (see serializer).
// Rev    : 1.0 - initial release
// ============================================================================
module user_au_i2s_tx
   import user_au_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   user_au_i2s_tx_if.slave  bus,
   output logic             i2s_sck_o,
   output logic             i2s_ws_o,
   output logic             i2s_sd_o
);
   localparam int unsigned       c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);

   logic [31:0]        r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
   logic [c_ptr_w:0]   r_count;
   logic               w_full, w_empty, w_push, w_pop, w_ser_pop, w_underrun_evt;
   logic [31:0]        w_word;

   logic               r_en, r_underrun, r_rvalid, r_err;
   logic [15:0]        r_div;
   logic [31:0]        r_rdata, w_rdata;
   logic [3:0]         r_rid;
   logic [1:0]         w_sel;
   logic               w_req, w_wr, w_unused_bits;

   assign w_full         = (r_count == c_depth);
   assign w_empty        = (r_count == '0);
   assign w_push         = bus.valid_i && !w_full;
   assign w_pop          = w_ser_pop && !w_empty;
   assign w_underrun_evt = w_ser_pop && w_empty;
   assign w_word         = w_empty ? 32'h0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= bus.data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         if (w_push && !w_pop)      r_count <= r_count + (c_ptr_w + 1)'(1);
         else if (!w_push && w_pop) r_count <= r_count - (c_ptr_w + 1)'(1);
      end
   end

   assign w_req = bus.obi_req_i.req;
   assign w_wr  = w_req && bus.obi_req_i.we;
   assign w_sel = bus.obi_req_i.addr[3:2];
   assign w_unused_bits = ^{bus.obi_req_i.addr[31:4], bus.obi_req_i.addr[1:0],
                            bus.obi_req_i.wdata[31:16]};

   always_comb begin
      w_rdata = '0;
      case (w_sel)
         c_reg_ctrl[3:2]:   w_rdata[c_ctrl_en] = r_en;
         c_reg_clkdiv[3:2]: w_rdata[15:0] = r_div;
         c_reg_status[3:2]: begin
            w_rdata[15:8] = 8'(r_count);
            w_rdata[0]    = r_underrun;
         end
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_en       <= 1'b0;
         r_div      <= '0;
         r_underrun <= 1'b0;
         r_rvalid   <= 1'b0;
         r_err      <= 1'b0;
         r_rdata    <= '0;
         r_rid      <= '0;
      end else begin
         r_rvalid <= w_req;
         r_rid    <= bus.obi_req_i.aid;
         r_err    <= w_wr && (w_sel == 2'd3);
         r_rdata  <= (w_req && !bus.obi_req_i.we) ? w_rdata : 32'h0;
         if (w_wr && (w_sel == c_reg_ctrl[3:2]))   r_en  <= bus.obi_req_i.wdata[c_ctrl_en];
         if (w_wr && (w_sel == c_reg_clkdiv[3:2])) r_div <= bus.obi_req_i.wdata[15:0];
         // A fresh underrun wins over a simultaneous clear so the event is never lost.
         if (w_underrun_evt)                            r_underrun <= 1'b1;
         else if (w_wr && (w_sel == c_reg_status[3:2])) r_underrun <= 1'b0;
      end
   end

   assign bus.obi_rsp_o = '{gnt: w_req, rvalid: r_rvalid, rdata: r_rdata, rid: r_rid, err: r_err};
   assign bus.ready_o   = !w_full;

   user_au_i2s_serializer u_serializer (
      .clk    (clk_i),
      .rst    (rst_i),
      .i_en   (r_en),
      .i_div  (r_div),
      .i_word (w_word),
      .o_pop  (w_ser_pop),
      .o_sck  (i2s_sck_o),
      .o_ws   (i2s_ws_o),
      .o_sd   (i2s_sd_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_user_au_i2s_tx.sv
`default_nettype none
// Bench for user_au_i2s_tx: frame-arithmetic reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_user_au_i2s_tx;
   import user_au_pkg::*;

   localparam int DEPTH = 4;
`ifdef USER_AU_I2S_DELAY_EN
   localparam int D = 1;
`else
   localparam int D = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sck, ws, sd;
   user_au_i2s_tx_if bus ();

   always #5 clk = ~clk;

   user_au_i2s_tx #(.FIFO_DEPTH(DEPTH)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .bus       (bus),
      .i2s_sck_o (sck),
      .i2s_ws_o  (ws),
      .i2s_sd_o  (sd)
   );

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] q[$];
   bit          m_en, m_under, m_run, m_rvalid, m_err;
   int          m_div, m_half, m_t;
   logic [31:0] m_word, m_prev, m_rdata;
   logic [3:0]  m_rid;

   always @(posedge clk or posedge rst) begin
      int  sel, old_size;
      bit  pop, evt;
      if (rst) begin
         q.delete();
         m_en = 0; m_under = 0; m_run = 0; m_rvalid = 0; m_err = 0;
         m_div = 0; m_half = 1; m_t = 0;
         m_word = 0; m_prev = 0; m_rdata = 0; m_rid = 0;
      end else begin
         old_size = q.size();
         sel = int'(bus.obi_req_i.addr[3:2]);
         m_rvalid = bus.obi_req_i.req;
         m_rid    = bus.obi_req_i.aid;
         m_err    = bus.obi_req_i.req && bus.obi_req_i.we && sel == 3;
         m_rdata  = 0;
         if (bus.obi_req_i.req && !bus.obi_req_i.we)
            case (sel)
               0: m_rdata = {31'h0, m_en};
               1: m_rdata = m_div;
               2: m_rdata = (old_size << 8) | m_under;
               default: m_rdata = 0;
            endcase
         pop = 0; evt = 0;
         if (!m_run) begin
            if (m_en) begin m_run = 1; m_t = 0; m_half = m_div + 1; pop = 1; end
         end else if (!m_en) begin
            m_run = 0;
         end else begin
            if ((m_t + 1) % (128 * m_half) == 0) pop = 1;
            m_t++;
         end
         if (pop) begin
            m_prev = m_word;
            if (q.size() == 0) begin m_word = 0; evt = 1; end
            else m_word = q.pop_front();
         end
         if (bus.valid_i && old_size < DEPTH) q.push_back(bus.data_i);
         if (bus.obi_req_i.req && bus.obi_req_i.we)
            case (sel)
               0: m_en  = bus.obi_req_i.wdata[0];
               1: m_div = int'(bus.obi_req_i.wdata[15:0]);
               2: m_under = 0;
               default: ;
            endcase
         if (evt) m_under = 1;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      int k, nb, b, pb;
      logic [31:0] w;
      logic e_sck, e_ws, e_sd;
      if (chk_on && !rst) begin
         e_sck = 0; e_ws = 0; e_sd = 0;
         if (m_run) begin
            k  = m_t / m_half;
            nb = k / 2;
            b  = nb % 64;
            e_sck = k[0];
            if (D == 0) begin
               e_ws = (b >= 32);
               e_sd = m_word[31 - (b % 32)];
            end else if (nb != 0) begin
               pb = (b + 63) % 64;
               w  = (b == 0) ? m_prev : m_word;
               e_ws = (pb >= 32);
               e_sd = w[31 - (pb % 32)];
            end
         end
         chk("sck", {31'h0, sck}, {31'h0, e_sck});
         chk("ws", {31'h0, ws}, {31'h0, e_ws});
         chk("sd", {31'h0, sd}, {31'h0, e_sd});
         chk("ready", {31'h0, bus.ready_o}, {31'h0, (q.size() < DEPTH)});
         chk("gnt", {31'h0, bus.obi_rsp_o.gnt}, {31'h0, bus.obi_req_i.req});
         chk("rvalid", {31'h0, bus.obi_rsp_o.rvalid}, {31'h0, m_rvalid});
         if (m_rvalid) begin
            chk("rdata", bus.obi_rsp_o.rdata, m_rdata);
            chk("err", {31'h0, bus.obi_rsp_o.err}, {31'h0, m_err});
            chk("rid", {28'h0, bus.obi_rsp_o.rid}, {28'h0, m_rid});
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic obi(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output logic rvalid);
      @(posedge clk); #1;
      bus.obi_req_i = '{req: 1'b1, we: we, addr: {28'h0, addr}, wdata: wdata, aid: 4'h5};
      @(posedge clk); #1;
      bus.obi_req_i.req = 1'b0;
      rdata  = bus.obi_rsp_o.rdata;
      err    = bus.obi_rsp_o.err;
      rvalid = bus.obi_rsp_o.rvalid;
   endtask

   task automatic push(input logic [31:0] d);
      @(posedge clk); #1;
      bus.valid_i = 1'b1;
      bus.data_i  = d;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
   endtask

   task automatic capture(output logic [63:0] ws_v, output logic [63:0] sd_v, output int period);
      int cyc, t0, t1, budget;
      bit got;
      logic prev;
      cyc = 0; t0 = 0; t1 = 0; prev = sck;
      ws_v = '0; sd_v = '0; period = 0;
      for (int i = 0; i < 64; i++) begin
         budget = 0; got = 0;
         while (!got && budget < 400) begin
            @(negedge clk);
            cyc++; budget++;
            if (sck && !prev) got = 1;
            prev = sck;
         end
         if (!got) begin
            chk("capture_timeout", 32'h0, 32'h1);
            return;
         end
         ws_v[i] = ws;
         sd_v[i] = sd;
         if (i == 0) t0 = cyc;
         if (i == 1) t1 = cyc;
      end
      period = t1 - t0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] rd;
      logic        er, rv;
      logic [63:0] wsv, sdv;
      int          per, n;
      logic [1:0]  sel;

      bus.obi_req_i = '0;
      bus.data_i    = '0;
      bus.valid_i   = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_on = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_sck", {31'h0, sck}, 32'h0);
      chk("rst_ws", {31'h0, ws}, 32'h0);
      chk("rst_sd", {31'h0, sd}, 32'h0);
      chk("rst_ready", {31'h0, bus.ready_o}, 32'h1);
      obi(1'b0, 4'h0, 32'h0, rd, er, rv);
      chk("rst_rd_ctrl", rd, 32'h0);
      chk("rst_rd_rvalid", {31'h0, rv}, 32'h1);
      obi(1'b0, 4'h4, 32'h0, rd, er, rv);
      chk("rst_rd_clkdiv", rd, 32'h0);
      obi(1'b0, 4'h8, 32'h0, rd, er, rv);
      chk("rst_rd_status", rd, 32'h0);

      // DIV=1, single word 0x8000_0001
      obi(1'b1, 4'h4, 32'h1, rd, er, rv);
      push(32'h8000_0001);
      obi(1'b1, 4'h0, 32'h1, rd, er, rv);
      capture(wsv, sdv, per);
      chk("sck_period_div1", per, 32'd4);
      chk("sd_first", {31'h0, sdv[0]}, {31'h0, (D == 0)});
      chk("sd_msb", {31'h0, sdv[0+D]}, 32'h1);
      chk("sd_b1", {31'h0, sdv[1+D]}, 32'h0);
      chk("sd_lsb_left", {31'h0, sdv[31+D]}, 32'h1);
      chk("sd_msb_right", {31'h0, sdv[32+D]}, 32'h1);
      chk("ws_left_end", {31'h0, wsv[31+D]}, 32'h0);
      chk("ws_rise", {31'h0, wsv[32+D]}, 32'h1);
      obi(1'b1, 4'h0, 32'h0, rd, er, rv);
      obi(1'b1, 4'hC, 32'h1, rd, er, rv);
      chk("reg3_err", {31'h0, er}, 32'h1);

      // enable with empty FIFO
      obi(1'b1, 4'h8, 32'h0, rd, er, rv);
      obi(1'b0, 4'h8, 32'h0, rd, er, rv);
      chk("status_cleared", rd, 32'h0);
      obi(1'b1, 4'h0, 32'h1, rd, er, rv);
      repeat (300) @(posedge clk);
      obi(1'b0, 4'h8, 32'h0, rd, er, rv);
      chk("underrun_set", rd, 32'h1);
      obi(1'b1, 4'h0, 32'h0, rd, er, rv);
      obi(1'b1, 4'h8, 32'h0, rd, er, rv);
      obi(1'b0, 4'h8, 32'h0, rd, er, rv);
      chk("underrun_clr", rd, 32'h0);

      // fill beyond depth while disabled, then drain
      for (int i = 0; i < 5; i++) push(32'h1000_0000 * (i + 1) + 32'h0000_00F1);
      @(negedge clk);
      chk("ready_full", {31'h0, bus.ready_o}, 32'h0);
      obi(1'b0, 4'h8, 32'h0, rd, er, rv);
      chk("level_full", rd, 32'h0000_0400);
      obi(1'b1, 4'h4, 32'h0, rd, er, rv);
      obi(1'b1, 4'h0, 32'h1, rd, er, rv);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("ready_after_pop", {31'h0, bus.ready_o}, 32'h1);
      repeat (4 * 128 + 60) @(posedge clk);
      obi(1'b1, 4'h0, 32'h0, rd, er, rv);

      // disable mid-frame, then restart with the next word
      push(32'hA5A5_5A5A);
      obi(1'b1, 4'h0, 32'h1, rd, er, rv);
      repeat (39) @(posedge clk);
      obi(1'b1, 4'h0, 32'h0, rd, er, rv);
      @(posedge clk); #1;
      chk("stop_sck", {31'h0, sck}, 32'h0);
      chk("stop_ws", {31'h0, ws}, 32'h0);
      chk("stop_sd", {31'h0, sd}, 32'h0);
      push(32'hF000_000F);
      obi(1'b1, 4'h0, 32'h1, rd, er, rv);
      capture(wsv, sdv, per);
      chk("restart_period", per, 32'd2);
      chk("restart_sd0", {31'h0, sdv[0]}, {31'h0, (D == 0)});
      chk("restart_sd1", {31'h0, sdv[1+D]}, 32'h1);
      chk("restart_sd4", {31'h0, sdv[4+D]}, 32'h0);
      obi(1'b1, 4'h0, 32'h0, rd, er, rv);

      // randomized traffic
      for (int it = 0; it < 6; it++) begin
         obi(1'b1, 4'h4, $urandom_range(0, 2), rd, er, rv);
         n = $urandom_range(0, 3);
         for (int p = 0; p < n; p++) push($urandom);
         obi(1'b1, 4'h0, 32'h1, rd, er, rv);
         n = $urandom_range(200, 1200);
         for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            bus.valid_i = ($urandom_range(0, 3) == 0);
            bus.data_i  = $urandom;
            bus.obi_req_i.req = ($urandom_range(0, 15) == 0);
            sel = 2'($urandom_range(0, 3));
            bus.obi_req_i.we    = (sel[1] == 1'b1) && ($urandom_range(0, 1) == 1);
            bus.obi_req_i.addr  = ($urandom & 32'hFFFF_FFF3) | {28'h0, sel, 2'b00};
            bus.obi_req_i.wdata = $urandom;
            bus.obi_req_i.aid   = 4'($urandom);
            if (it == 2 && c == n / 2) begin
               #2 rst = 1'b1;
               #1;
               chk("async_rst_sck", {31'h0, sck}, 32'h0);
               chk("async_rst_ws", {31'h0, ws}, 32'h0);
               chk("async_rst_sd", {31'h0, sd}, 32'h0);
               chk("async_rst_ready", {31'h0, bus.ready_o}, 32'h1);
               bus.valid_i = 1'b0;
               bus.obi_req_i.req = 1'b0;
               @(posedge clk); #1 rst = 1'b0;
            end
         end
         @(posedge clk); #1;
         bus.valid_i = 1'b0;
         bus.obi_req_i.req = 1'b0;
         obi(1'b1, 4'h0, 32'h0, rd, er, rv);
      end

      repeat (4) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
